apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master_if.sv | 37 +++
 rtl/apb_req_master.sv | 104 ++++++++++
 tb/tb_apb_req_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// Requester-side request/response handshake plus the APB master bus,
// bundled so the master and its environment share one port list.
interface apb_req_master_if #(
  parameter int APB_ADDR_WIDTH = 12
) ();
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]               req_wdata_i;
  logic                      req_write_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [31:0]               rsp_rdata_o;
  logic                      rsp_err_o;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding APB master: converts one valid/ready request into a
// SETUP/ACCESS transfer with an optional ACCESS-phase timeout.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  apb_req_master_if.master  bus
);

  localparam int          CW  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      timeout;

  // Abort on the ACCESS cycle whose stall would bring the counter to the limit.
  assign timeout = (TMO != 32'd0) && !bus.PREADY && ((32'(cnt_q) + 32'd1) >= TMO);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_d  = SETUP;
          cnt_d    = '0;
          paddr_d  = bus.req_addr_i;
          pwrite_d = bus.req_write_i;
          pwdata_d = bus.req_write_i ? bus.req_wdata_i : 32'd0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          state_d = RESP;
          rdata_d = pwrite_q ? 32'd0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
        end else begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (timeout) begin
            state_d = RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      RESP: begin
        // Clear the response on consumption so it reads zero while not valid.
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE) && RSTN;
  assign bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE     = (state_q == ACCESS);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = (state_q == RESP) ? rdata_q : 32'd0;
  assign bus.rsp_err_o   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: vector table driven through a bus-level APB
// responder, responses checked against a scoreboard queue.
module tb_apb_req_master;
  localparam int AW = 12;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  apb_req_master_if #(.APB_ADDR_WIDTH(AW)) bi ();
  apb_req_master_if #(.APB_ADDR_WIDTH(AW)) bi0 ();

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .bus(bi)
  );
  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .bus(bi0)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   prdata;
    logic          slverr;
    int            wait_c;
    int            stall;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vt[7];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, acc, lat, exp_acc;
    rsp_t r;
    logic [31:0] exp_pw, rd0;
    logic er0;
    exp_pw  = v.w ? v.wdata : 32'd0;
    exp_acc = (v.wait_c >= 8) ? 8 : v.wait_c + 1;
    @(negedge CLK);
    bi.req_valid_i = 1'b1;
    bi.req_addr_i  = v.addr;
    bi.req_wdata_i = v.wdata;
    bi.req_write_i = v.w;
    n = 0;
    while (!bi.req_ready_o && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready", 32'(bi.req_ready_o), 32'd1);
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(negedge CLK);
    bi.req_valid_i = 1'b0;
    bi.req_addr_i  = ~v.addr;
    bi.req_wdata_i = ~v.wdata;
    bi.req_write_i = ~v.w;
    chk("setup psel/penable", 32'({bi.PSEL, bi.PENABLE}), 32'd2);
    chk("setup paddr", 32'(bi.PADDR), 32'(v.addr));
    chk("setup pwdata", bi.PWDATA, exp_pw);
    chk("setup pwrite", 32'(bi.PWRITE), 32'(v.w));
    bi.PREADY = 1'b1;
    bi.PRDATA = 32'hBAD0_0000;
    acc = 0;
    lat = 1;
    n = 0;
    do begin
      @(negedge CLK);
      lat++;
      n++;
      if (bi.PSEL && bi.PENABLE) begin
        acc++;
        chk("access paddr", 32'(bi.PADDR), 32'(v.addr));
        chk("access pwdata", bi.PWDATA, exp_pw);
        if (acc == v.wait_c + 1) begin
          bi.PREADY  = 1'b1;
          bi.PRDATA  = v.prdata;
          bi.PSLVERR = v.slverr;
        end else begin
          bi.PREADY  = 1'b0;
          bi.PRDATA  = 32'hBAD0_0000 | 32'(acc);
          bi.PSLVERR = 1'b1;
        end
      end
    end while (bi.PSEL && n < 300);
    bi.PREADY  = 1'b0;
    bi.PSLVERR = 1'b0;
    chk("psel dropped", 32'(bi.PSEL), 32'd0);
    chk("access cycles", 32'(acc), 32'(exp_acc));
    chk("rsp latency", 32'(lat), 32'(exp_acc + 2));
    chk("rsp_valid", 32'(bi.rsp_valid_o), 32'd1);
    rd0 = bi.rsp_rdata_o;
    er0 = bi.rsp_err_o;
    if (v.stall > 0) begin
      bi.req_valid_i = 1'b1;
      bi.req_addr_i  = 12'h123;
      bi.req_write_i = 1'b1;
      for (int i = 0; i < v.stall; i++) begin
        @(negedge CLK);
        chk("stall rsp_valid", 32'(bi.rsp_valid_o), 32'd1);
        chk("stall rdata", bi.rsp_rdata_o, rd0);
        chk("stall err", 32'(bi.rsp_err_o), 32'(er0));
        chk("stall req_ready", 32'(bi.req_ready_o), 32'd0);
        chk("stall psel", 32'(bi.PSEL), 32'd0);
      end
    end
    bi.rsp_ready_i = 1'b1;
    r = sb.pop_front();
    chk("rsp rdata", bi.rsp_rdata_o, r.rdata);
    chk("rsp err", 32'(bi.rsp_err_o), 32'(r.err));
    @(negedge CLK);
    bi.rsp_ready_i = 1'b0;
    chk("idle rsp_valid", 32'(bi.rsp_valid_o), 32'd0);
    chk("idle rdata/err", bi.rsp_rdata_o | 32'(bi.rsp_err_o), 32'd0);
    chk("idle req_ready", 32'(bi.req_ready_o), 32'd1);
    bi.req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    {bi.req_valid_i, bi.req_addr_i, bi.req_wdata_i, bi.req_write_i, bi.rsp_ready_i} = '0;
    {bi.PRDATA, bi.PREADY, bi.PSLVERR} = '0;
    {bi0.req_valid_i, bi0.req_addr_i, bi0.req_wdata_i, bi0.req_write_i, bi0.rsp_ready_i} = '0;
    {bi0.PRDATA, bi0.PREADY, bi0.PSLVERR} = '0;

    //        w  addr     wdata          prdata         err wait stall exp_rdata      exp_err
    vt[0] = '{1'b0, 12'h014, 32'h0,         32'h60,        1'b0, 0,   0, 32'h60,        1'b0};
    vt[1] = '{1'b1, 12'h00C, 32'h83,        32'h1111,      1'b0, 3,   0, 32'h0,         1'b0};
    vt[2] = '{1'b0, 12'h020, 32'h0,         32'hDEAD,      1'b1, 1,   0, 32'hDEAD,      1'b1};
    vt[3] = '{1'b0, 12'h0FF, 32'h0,         32'h7777,      1'b0, 255, 0, 32'h0,         1'b1};
    vt[4] = '{1'b1, 12'hFFF, 32'hFFFFFFFF,  32'h2222,      1'b1, 0,   5, 32'h0,         1'b1};
    vt[5] = '{1'b0, 12'h800, 32'h0,         32'hA5A55A5A,  1'b0, 7,   0, 32'hA5A55A5A,  1'b0};
    vt[6] = '{1'b1, 12'h004, 32'h12345678,  32'h3333,      1'b0, 6,   2, 32'h0,         1'b0};

    #2;
    chk("reset psel/penable", 32'({bi.PSEL, bi.PENABLE}), 32'd0);
    chk("reset paddr/pwrite", 32'({bi.PADDR, bi.PWRITE}), 32'd0);
    chk("reset pwdata", bi.PWDATA, 32'd0);
    chk("reset rsp", 32'({bi.rsp_valid_o, bi.rsp_err_o}) | bi.rsp_rdata_o, 32'd0);
    chk("reset req_ready", 32'(bi.req_ready_o), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    chk("post-reset req_ready", 32'(bi.req_ready_o), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // No timeout: PREADY held low far past 8 cycles must keep ACCESS alive.
    @(negedge CLK);
    bi0.req_valid_i = 1'b1;
    bi0.req_addr_i  = 12'h044;
    bi0.req_write_i = 1'b0;
    @(negedge CLK);
    bi0.req_valid_i = 1'b0;
    repeat (30) @(negedge CLK);
    chk("t0 still in access", 32'({bi0.PSEL, bi0.PENABLE}), 32'd3);
    chk("t0 no rsp", 32'(bi0.rsp_valid_o), 32'd0);
    bi0.PREADY = 1'b1;
    bi0.PRDATA = 32'h0000_1234;
    @(negedge CLK);
    bi0.PREADY = 1'b0;
    chk("t0 rsp_valid", 32'(bi0.rsp_valid_o), 32'd1);
    chk("t0 rdata", bi0.rsp_rdata_o, 32'h0000_1234);
    bi0.rsp_ready_i = 1'b1;
    @(negedge CLK);
    bi0.rsp_ready_i = 1'b0;
    chk("t0 back idle", 32'(bi0.req_ready_o), 32'd1);

    // Asynchronous reset in the middle of an ACCESS phase.
    bi.req_valid_i = 1'b1;
    bi.req_addr_i  = 12'h0AA;
    bi.req_write_i = 1'b1;
    bi.req_wdata_i = 32'h55;
    @(negedge CLK);
    bi.req_valid_i = 1'b0;
    bi.PREADY = 1'b0;
    @(negedge CLK);
    chk("pre-reset access", 32'({bi.PSEL, bi.PENABLE}), 32'd3);
    #2;
    RSTN = 1'b0;
    #1;
    chk("async rst psel/penable", 32'({bi.PSEL, bi.PENABLE}), 32'd0);
    chk("async rst paddr/pwrite", 32'({bi.PADDR, bi.PWRITE}), 32'd0);
    chk("async rst pwdata", bi.PWDATA, 32'd0);
    chk("async rst req_ready", 32'(bi.req_ready_o), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    chk("release req_ready", 32'(bi.req_ready_o), 32'd1);
    seen = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bi.rsp_valid_o || bi.PSEL) seen = 1'b1;
      n++;
    end
    chk("no rsp after reset", 32'(seen), 32'd0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
